// File: rtl/router_pkt_tx.sv
// router_pkt_tx: packet source for the 1x3 router input port.
// Buffers a host payload, then sends header, payload and an XOR parity byte
// to the router, holding the current byte while the router asserts busy.
// Optional feature macro: PARITY_INJECT_EN adds the inj_err input, which
// inverts bit 0 of the transmitted parity byte of the requested packet.
//
// Handshakes: the host byte moves on a rising clock edge where
// pld_valid && pld_ready. The router byte moves on a rising clock edge where
// pkt state is HDR/PLD/PAR and busy == 0. A request moves on a rising clock
// edge where start && tx_ready.
module router_pkt_tx #(
  parameter int GAP_CYCLES = 1,
  parameter int MAX_LEN    = 63
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       start,
  input  logic [1:0] dest_addr,
  input  logic [5:0] pld_len,
`ifdef PARITY_INJECT_EN
  input  logic       inj_err,
`endif
  input  logic       pld_valid,
  input  logic [7:0] pld_data,
  output logic       pld_ready,
  input  logic       busy,
  output logic       pkt_valid,
  output logic [7:0] data_out,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       err,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_HDR  = 3'd2,
    S_PLD  = 3'd3,
    S_PAR  = 3'd4,
    S_GAP  = 3'd5
  } state_t;

  localparam logic [6:0]  MAX_LEN_W = 7'(MAX_LEN);
  localparam logic [15:0] GAP_LAST  = 16'(GAP_CYCLES - 1);

  state_t      state, state_nxt;
  logic [7:0]  pld_buf [MAX_LEN];
  logic [7:0]  header_q;
  logic [7:0]  parity_q;
  logic [5:0]  len_q;
  logic [5:0]  wptr;
  logic [5:0]  rptr;
  logic [15:0] gap_cnt;
  logic        tx_done_q;
  logic        err_q;
  logic        inj_q;
  logic        inj_in;
  logic        bad_req;
  logic [7:0]  hdr_in;
  logic        last_wr;
  logic        last_rd;
  logic [7:0]  parity_out;

`ifdef PARITY_INJECT_EN
  assign inj_in = inj_err;
`else
  assign inj_in = 1'b0;
`endif

  assign hdr_in     = {pld_len, dest_addr};
  assign bad_req    = (dest_addr == 2'd3) || (pld_len == 6'd0) ||
                      ({1'b0, pld_len} > MAX_LEN_W);
  assign last_wr    = pld_valid && (wptr == len_q - 6'd1);
  assign last_rd    = !busy && (rptr == len_q - 6'd1);
  assign parity_out = parity_q ^ {7'd0, inj_q};

  // State register; reset aborts any packet in flight immediately.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic: busy only matters while a byte is on the wire.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start && !bad_req)           state_nxt = S_LOAD;
      S_LOAD: if (last_wr)                     state_nxt = S_HDR;
      S_HDR:  if (!busy)                       state_nxt = S_PLD;
      S_PLD:  if (last_rd)                     state_nxt = S_PAR;
      S_PAR:  if (!busy)                       state_nxt = S_GAP;
      S_GAP:  if (gap_cnt == GAP_LAST)         state_nxt = S_IDLE;
      default:                                 state_nxt = S_IDLE;
    endcase
  end

  // Request latch, pointers, running parity, gap counter and status pulses.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      header_q  <= 8'd0;
      parity_q  <= 8'd0;
      len_q     <= 6'd0;
      wptr      <= 6'd0;
      rptr      <= 6'd0;
      gap_cnt   <= 16'd0;
      tx_done_q <= 1'b0;
      err_q     <= 1'b0;
      inj_q     <= 1'b0;
    end else begin
      tx_done_q <= 1'b0;
      err_q     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (bad_req) begin
              err_q <= 1'b1;
            end else begin
              header_q <= hdr_in;
              parity_q <= hdr_in;
              len_q    <= pld_len;
              wptr     <= 6'd0;
              rptr     <= 6'd0;
              inj_q    <= inj_in;
            end
          end
        end
        S_LOAD: begin
          if (pld_valid) begin
            wptr     <= wptr + 6'd1;
            parity_q <= parity_q ^ pld_data;
          end
        end
        S_PLD: begin
          if (!busy) rptr <= rptr + 6'd1;
        end
        S_PAR: begin
          if (!busy) begin
            tx_done_q <= 1'b1;
            gap_cnt   <= 16'd0;
          end
        end
        S_GAP: begin
          gap_cnt <= gap_cnt + 16'd1;
        end
        default: ;
      endcase
    end
  end

  // Payload buffer write port; contents need no reset since wptr gates reads.
  always_ff @(posedge clock) begin
    if (state == S_LOAD && pld_valid) pld_buf[wptr] <= pld_data;
  end

  // Wire-side byte mux: zero whenever no byte is being offered.
  always_comb begin
    data_out = 8'd0;
    case (state)
      S_HDR:   data_out = header_q;
      S_PLD:   data_out = pld_buf[rptr];
      S_PAR:   data_out = parity_out;
      default: data_out = 8'd0;
    endcase
  end

  assign pkt_valid = (state == S_HDR) || (state == S_PLD);
  assign pld_ready = (state == S_LOAD);
  assign tx_ready  = (state == S_IDLE);
  assign tx_done   = tx_done_q;
  assign err       = err_q;
  assign state_dbg = state;

endmodule

// File: tb/tb_router_pkt_tx.sv
// tb_router_pkt_tx: directed bench for router_pkt_tx.
// Drives requests and payloads, then walks the wire byte by byte against
// an expected queue built from a small header/payload/parity model.
module tb_router_pkt_tx;

  localparam int GAP_CYCLES = 1;
  localparam int MAX_LEN    = 63;

  logic       clock;
  logic       resetn;
  logic       start;
  logic [1:0] dest_addr;
  logic [5:0] pld_len;
  logic       pld_valid;
  logic [7:0] pld_data;
  logic       pld_ready;
  logic       busy;
  logic       pkt_valid;
  logic [7:0] data_out;
  logic       tx_ready;
  logic       tx_done;
  logic       err;
  logic [2:0] state_dbg;
`ifdef PARITY_INJECT_EN
  logic       inj_r;
`endif

  int         n_checks;
  int         n_fail;
  logic [7:0] pay [64];
  logic [7:0] exp_q [$];

  router_pkt_tx #(.GAP_CYCLES(GAP_CYCLES), .MAX_LEN(MAX_LEN)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .start     (start),
    .dest_addr (dest_addr),
    .pld_len   (pld_len),
`ifdef PARITY_INJECT_EN
    .inj_err   (inj_r),
`endif
    .pld_valid (pld_valid),
    .pld_data  (pld_data),
    .pld_ready (pld_ready),
    .busy      (busy),
    .pkt_valid (pkt_valid),
    .data_out  (data_out),
    .tx_ready  (tx_ready),
    .tx_done   (tx_done),
    .err       (err),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // driver: one-cycle request
  task automatic start_req(input logic [1:0] a, input logic [5:0] l, input logic inj);
    start     = 1'b1;
    dest_addr = a;
    pld_len   = l;
`ifdef PARITY_INJECT_EN
    inj_r     = inj;
`else
    if (inj) $display("note: parity injection not built in");
`endif
    step();
    start = 1'b0;
`ifdef PARITY_INJECT_EN
    inj_r = 1'b0;
`endif
  endtask

  // driver: stream pay[0..len-1], optionally with pld_valid on every other cycle
  task automatic load_payload(input int len, input bit toggle);
    int i;
    int cyc;
    bit acc;
    i   = 0;
    cyc = 0;
    check("ld_ready_first", pld_ready, 1);
    while (i < len && cyc < 400) begin
      pld_valid = toggle ? ((cyc % 2) == 0) : 1'b1;
      pld_data  = pay[i];
      acc       = pld_valid && pld_ready;
      step();
      if (acc) i++;
      cyc++;
    end
    pld_valid = 1'b0;
    check("ld_count", i, len);
    check("ld_ready_off", pld_ready, 0);
  endtask

  // scoreboard: expected wire bytes, optional busy hold at byte index hold_at
  task automatic wire_check(input logic [1:0] a, input int len, input int hold_at,
                            input int hold_n, input logic inj);
    logic [7:0] hdr;
    logic [7:0] par;
    logic [7:0] exp;
    logic [5:0] l6;
    l6  = len[5:0];
    hdr = {l6, a};
    par = hdr;
    exp_q.delete();
    exp_q.push_back(hdr);
    for (int i = 0; i < len; i++) begin
      exp_q.push_back(pay[i]);
      par = par ^ pay[i];
    end
    exp_q.push_back(par ^ {7'd0, inj});
    for (int k = 0; k < len + 2; k++) begin
      exp = exp_q.pop_front();
      check($sformatf("wire_byte%0d", k), data_out, exp);
      check($sformatf("wire_valid%0d", k), pkt_valid, (k <= len));
      if (k == hold_at) begin
        busy = 1'b1;
        for (int h = 0; h < hold_n; h++) begin
          step();
          check("hold_byte", data_out, exp);
          check("hold_valid", pkt_valid, (k <= len));
        end
        busy = 1'b0;
      end
      step();
    end
    check("done_pulse", tx_done, 1);
    check("gap_data", data_out, 0);
    check("gap_valid", pkt_valid, 0);
    check("gap_not_ready", tx_ready, 0);
    for (int g = 0; g < GAP_CYCLES; g++) step();
    check("idle_ready", tx_ready, 1);
    check("done_single", tx_done, 0);
    check("q_empty", exp_q.size(), 0);
  endtask

  task automatic set_pay3(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    pay[0] = b0;
    pay[1] = b1;
    pay[2] = b2;
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    resetn    = 1'b0;
    start     = 1'b0;
    dest_addr = 2'd0;
    pld_len   = 6'd0;
    pld_valid = 1'b0;
    pld_data  = 8'd0;
    busy      = 1'b0;
`ifdef PARITY_INJECT_EN
    inj_r     = 1'b0;
`endif
    step();
    step();
    check("rst_data", data_out, 0);
    check("rst_valid", pkt_valid, 0);
    check("rst_pld_ready", pld_ready, 0);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_tx_done", tx_done, 0);
    check("rst_err", err, 0);
    resetn = 1'b1;
    step();

    // basic packet: header 0D, parity 0D
    set_pay3(8'h11, 8'h22, 8'h33);
    start_req(2'd1, 6'd3, 1'b0);
    load_payload(3, 1'b0);
    wire_check(2'd1, 3, -1, 0, 1'b0);

    // same packet, router busy for two cycles while 22 is shown
    start_req(2'd1, 6'd3, 1'b0);
    load_payload(3, 1'b0);
    wire_check(2'd1, 3, 2, 2, 1'b0);

    // rejected requests
    start_req(2'd3, 6'd3, 1'b0);
    check("err_addr", err, 1);
    check("err_addr_ready", tx_ready, 1);
    check("err_addr_pld", pld_ready, 0);
    check("err_addr_valid", pkt_valid, 0);
    step();
    check("err_addr_pulse", err, 0);
    start_req(2'd0, 6'd0, 1'b0);
    check("err_len0", err, 1);
    check("err_len0_ready", tx_ready, 1);
    check("err_len0_pld", pld_ready, 0);
    step();
    check("err_len0_pulse", err, 0);

    // max length, host valid toggling
    for (int i = 0; i < 63; i++) pay[i] = 8'(i);
    start_req(2'd2, 6'd63, 1'b0);
    load_payload(63, 1'b1);
    check("max_header", data_out, 8'hFE);
    wire_check(2'd2, 63, -1, 0, 1'b0);

    // async reset while the second payload byte is on the wire
    set_pay3(8'h11, 8'h22, 8'h33);
    start_req(2'd1, 6'd3, 1'b0);
    load_payload(3, 1'b0);
    step();
    step();
    check("pre_rst_byte", data_out, 8'h22);
    resetn = 1'b0;
    #1;
    check("arst_valid", pkt_valid, 0);
    check("arst_data", data_out, 0);
    check("arst_ready", tx_ready, 1);
    step();
    resetn = 1'b1;
    step();
    set_pay3(8'hAA, 8'h55, 8'h3C);
    start_req(2'd0, 6'd3, 1'b0);
    load_payload(3, 1'b0);
    wire_check(2'd0, 3, -1, 0, 1'b0);

`ifdef PARITY_INJECT_EN
    // injected parity error: parity byte 0C instead of 0D
    set_pay3(8'h11, 8'h22, 8'h33);
    start_req(2'd1, 6'd3, 1'b1);
    load_payload(3, 1'b0);
    wire_check(2'd1, 3, -1, 0, 1'b1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
